// File: rtl/fir_pkg.sv
// Shared constants and rounding/saturation helpers for the serial FIR output stages.
package fir_pkg;

   localparam int FIR_IN_W  = 29;
   localparam int FIR_OUT_W = 12;
   localparam int FIR_SHIFT = 11;

   // Adding half an LSB before the arithmetic shift rounds half-way values toward +inf.
   function automatic longint rnd_shr(input longint x, input int sh);
      return (x + (longint'(1) <<< (sh - 1))) >>> sh;
   endfunction

   function automatic logic is_sat(input longint x, input int ow);
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (ow - 1)) - 1;
      lo = -(longint'(1) <<< (ow - 1));
      return (x > hi) || (x < lo);
   endfunction

   function automatic longint sat_val(input longint x, input int ow);
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (ow - 1)) - 1;
      lo = -(longint'(1) <<< (ow - 1));
      if (x > hi)      return hi;
      else if (x < lo) return lo;
      else             return x;
   endfunction

   function automatic longint sat_round(input longint x, input int sh, input int ow);
      return sat_val(rnd_shr(x, sh), ow);
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; rd_data always presents the head entry.
module sync_fifo_fwft #(
   parameter int W     = 12,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wptr;
   logic [AW:0]  rptr;
   logic [W-1:0] mem [DEPTH];
   logic         wr_ok;
   logic         rd_ok;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

   // At full a same-cycle read frees the slot being written.
   assign rd_ok = rd_en && !empty;
   assign wr_ok = wr_en && (!full || rd_ok);

   assign rd_data = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_ok) begin
            mem[wptr[AW-1:0]] <= wr_data;
            wptr              <= wptr + (AW+1)'(1);
         end
         if (rd_ok) rptr <= rptr + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/fir_out_quant.sv
// FIR output quantiser: round-half-up shift, saturate, FWFT buffer with drop/saturation reporting.
module fir_out_quant
   import fir_pkg::*;
#(
   parameter int IN_W  = FIR_IN_W,
   parameter int OUT_W = FIR_OUT_W,
   parameter int SHIFT = FIR_SHIFT,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [IN_W-1:0]  din,
   input  logic                    din_vld,
   output logic signed [OUT_W-1:0] dout,
   output logic                    dout_vld,
   input  logic                    dout_rdy,
   output logic                    sat_flag,
   output logic                    ovf_flag,
   output logic [CNT_W-1:0]        drop_cnt,
   input  logic                    clr
);

   logic signed [IN_W:0]  r1;
   logic                  v1;
   logic [OUT_W-1:0]      q2;
   logic                  s2;
   logic                  v2;
   logic                  full;
   logic                  empty;
   logic                  rd_en;
   logic                  wr_en;
   logic                  drop;
   logic [OUT_W-1:0]      rd_data;

   // Stage 1: rounded shift, one bit wider than din so the half-LSB add cannot overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         r1 <= '0;
         v1 <= 1'b0;
      end else begin
         v1 <= din_vld;
         if (din_vld) r1 <= (IN_W+1)'(rnd_shr(longint'(din), SHIFT));
      end
   end

   // Stage 2: clip to the output range.
   always_ff @(posedge clk) begin
      if (rst) begin
         q2 <= '0;
         s2 <= 1'b0;
         v2 <= 1'b0;
      end else begin
         v2 <= v1;
         q2 <= OUT_W'(sat_val(longint'(r1), OUT_W));
         s2 <= is_sat(longint'(r1), OUT_W);
      end
   end

   assign dout_vld = !empty;
   assign rd_en    = dout_vld && dout_rdy;
   assign wr_en    = v2 && (!full || rd_en);
   assign drop     = v2 && !wr_en;
   assign dout     = rd_data;

   sync_fifo_fwft #(
      .W     (OUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (q2),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty)
   );

   // clr is applied first so a same-cycle event still lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_flag <= 1'b0;
         ovf_flag <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (clr) begin
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
         end
         if (v2 && s2) sat_flag <= 1'b1;
         if (drop)     ovf_flag <= 1'b1;
         if (clr)
            drop_cnt <= drop ? CNT_W'(1) : '0;
         else if (drop && (drop_cnt != {CNT_W{1'b1}}))
            drop_cnt <= drop_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fir_out_quant.sv
// Scoreboard bench for fir_out_quant: directed samples with hand-computed outputs.
module tb_fir_out_quant;

   logic               clk;
   logic               rst;
   logic signed [28:0] din;
   logic               din_vld;
   logic signed [11:0] dout;
   logic               dout_vld;
   logic               dout_rdy;
   logic               sat_flag;
   logic               ovf_flag;
   logic [7:0]         drop_cnt;
   logic               clr;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int exp_v;

   fir_out_quant dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din),
      .din_vld  (din_vld),
      .dout     (dout),
      .dout_vld (dout_vld),
      .dout_rdy (dout_rdy),
      .sat_flag (sat_flag),
      .ovf_flag (ovf_flag),
      .drop_cnt (drop_cnt),
      .clr      (clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Monitor: every handshake pops the next expected sample.
   always @(negedge clk) begin
      if (!rst && dout_vld && dout_rdy) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %0d, required no output", dout);
         end else begin
            exp_v = exp_q.pop_front();
            chk("dout", int'(dout), exp_v);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Returns 1 ns after the edge that samples the strobe.
   task automatic send(input int v);
      din     = 29'(v);
      din_vld = 1'b1;
      tick(1);
      din_vld = 1'b0;
      din     = 29'($urandom);
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; din = '0; din_vld = 1'b0; dout_rdy = 1'b1; clr = 1'b0;
      tick(3);
      chk("rst_dout_vld", int'(dout_vld), 0);
      chk("rst_dout", int'(dout), 0);
      chk("rst_sat", int'(sat_flag), 0);
      chk("rst_ovf", int'(ovf_flag), 0);
      chk("rst_drop_cnt", int'(drop_cnt), 0);
      rst = 1'b0;
      tick(2);

      // Rounding and latency.
      exp_q.push_back(6);
      send(11264);
      chk("lat_n1", int'(dout_vld), 0);
      tick(1);
      chk("lat_n2", int'(dout_vld), 0);
      tick(1);
      chk("lat_n3", int'(dout_vld), 1);
      tick(6);
      exp_q.push_back(0);  send(-1024);  tick(7);
      exp_q.push_back(-1); send(-3072);  tick(7);
      exp_q.push_back(5);  send(10240);  tick(7);
      chk("no_sat_yet", int'(sat_flag), 0);

      // Saturation.
      exp_q.push_back(2047);  send(4193280);  tick(5);
      chk("sat_pos_flag", int'(sat_flag), 1);
      tick(2);
      exp_q.push_back(-2048); send(-4196352); tick(7);
      pulse_clr();
      chk("sat_clr", int'(sat_flag), 0);
      exp_q.push_back(2047);  send(4192256);  tick(7);
      chk("sat_edge_none", int'(sat_flag), 0);

      // Back-pressure: six strobes, only four fit.
      dout_rdy = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         if (k <= 4) exp_q.push_back(k);
         send(k * 2048);
         tick(7);
      end
      chk("bp_ovf", int'(ovf_flag), 1);
      chk("bp_drop_cnt", int'(drop_cnt), 2);
      chk("bp_vld", int'(dout_vld), 1);
      chk("bp_head", int'(dout), 1);
      tick(3);
      chk("bp_hold", int'(dout), 1);
      dout_rdy = 1'b1;
      tick(6);
      chk("bp_drained", int'(dout_vld), 0);

      // Full FIFO with a read in the write cycle.
      pulse_clr();
      dout_rdy = 1'b0;
      for (int k = 7; k <= 10; k++) begin
         exp_q.push_back(k);
         send(k * 2048);
         tick(3);
      end
      exp_q.push_back(11);
      send(11 * 2048);
      tick(1);
      dout_rdy = 1'b1;
      tick(1);
      dout_rdy = 1'b0;
      tick(3);
      chk("fr_drop_cnt", int'(drop_cnt), 0);
      chk("fr_ovf", int'(ovf_flag), 0);
      chk("fr_head", int'(dout), 8);
      dout_rdy = 1'b1;
      tick(3);
      chk("fr_still_vld", int'(dout_vld), 1);
      tick(1);
      chk("fr_empty_after4", int'(dout_vld), 0);

      // Drop-counter saturation and clr.
      dout_rdy = 1'b0;
      pulse_clr();
      for (int k = 1; k <= 4; k++) begin
         exp_q.push_back(k);
         send(k * 2048);
         tick(1);
      end
      for (int i = 0; i < 300; i++) begin
         send(i * 2048);
         tick(1);
      end
      tick(4);
      chk("cnt_sat", int'(drop_cnt), 255);
      pulse_clr();
      chk("cnt_clr", int'(drop_cnt), 0);
      chk("ovf_clr", int'(ovf_flag), 0);
      send(99 * 2048);
      tick(1);
      pulse_clr();
      chk("clr_vs_drop_cnt", int'(drop_cnt), 1);
      chk("clr_vs_drop_ovf", int'(ovf_flag), 1);

      // Reset mid-stream: three queued, one in flight.
      dout_rdy = 1'b1;
      tick(1);
      dout_rdy = 1'b0;
      tick(2);
      send(77 * 2048);
      rst = 1'b1;
      exp_q.delete();
      tick(1);
      chk("mrst_vld", int'(dout_vld), 0);
      chk("mrst_ovf", int'(ovf_flag), 0);
      chk("mrst_cnt", int'(drop_cnt), 0);
      rst = 1'b0;
      tick(6);
      chk("mrst_no_late", int'(dout_vld), 0);

      // Recovery after reset.
      dout_rdy = 1'b1;
      exp_q.push_back(-5);
      send(-5 * 2048);
      tick(8);
      chk("sb_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
